// File: rtl/arcsin_taylor_pkg.sv
// Shared formats, series coefficients and FSM encoding for the arcsin Taylor core.
// Pure declarations, no timing behaviour.
// No handshake; imported by the core and its datapath helper.
package arcsin_taylor_pkg;

    // Fractional bit counts of the input (Q4.12), output (Q4.8) and coefficients (Q0.16)
    localparam int Q_IN_FRAC   = 12;
    localparam int Q_OUT_FRAC  = 8;
    localparam int Q_COEF_FRAC = 16;

    // Internal magnitudes are unsigned Q.12 in 18 bits; products are 36 bits
    localparam int MAG_W  = 18;
    localparam int PROD_W = 2 * MAG_W;

    // The shared multiplier always drops Q_IN_FRAC bits; coefficient products need 4 more
    localparam int ACC_EXTRA_SHR = Q_COEF_FRAC - Q_IN_FRAC;
    localparam int RND_SHR       = Q_IN_FRAC - Q_OUT_FRAC;

    localparam int ONE_Q12    = 4096;
    localparam int PI_HALF_Q8 = 402;

    // Odd-power coefficients for x^3, x^5, x^7, x^9: 1/6, 3/40, 15/336, 35/1152 (index 0 first)
    localparam logic [3:0][15:0] COEF = {16'd1991, 16'd2926, 16'd4915, 16'd10923};

    typedef enum logic [2:0] {
        IDLE,
        SQR,
        POW,
        ACC,
        OUT
    } state_t;

endpackage

// File: rtl/arcsin_taylor_mul.sv
// Unsigned W x W multiplier with a fixed truncating right shift of the product.
// Purely combinational, zero latency.
// No handshake; the caller muxes operands and registers the result.
module fxp_mul_shr #(
    parameter int W     = 18,
    parameter int SHIFT = 12
) (
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         b,
    output logic [2*W-SHIFT-1:0] y
);

    localparam int YW = 2 * W - SHIFT;

    logic [2*W-1:0] prod;

    assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    assign y    = YW'(prod >> SHIFT);

endmodule

// File: rtl/arcsin_taylor.sv
// arcsin(x) of a signed Q4.12 sine value via an odd-power Taylor series, result signed Q4.8.
// Latency: res_vld_o pulses in the cycle after the (2*N_TERMS-1)-th edge following acceptance.
// Backpressure: in_rdy_o is high only in IDLE; arg_vld_i while busy is ignored (no queue).
// Optional ARCSIN_SAT_EN: |x| > 1.0 returns +/-pi/2 with range_err_o; otherwise |x| is clamped to 1.0.
module arcsin_taylor
    import arcsin_taylor_pkg::*;
#(
    parameter int INT_BITS_I = 16,
    parameter int INT_BITS_O = 12,
    parameter int N_TERMS    = 4
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic [INT_BITS_I-1:0] x_i,
    input  logic                  arg_vld_i,
    output logic                  in_rdy_o,
    output logic [INT_BITS_O-1:0] asinx_o,
    output logic                  res_vld_o
`ifdef ARCSIN_SAT_EN
    ,
    output logic                  range_err_o
`endif
);

    localparam int                  IN_EXT_W = INT_BITS_I + 1;
    localparam logic [IN_EXT_W-1:0] ONE_IN   = IN_EXT_W'(ONE_Q12);
    localparam logic [IN_EXT_W-1:0] LSB_IN   = 1;
    localparam logic [2:0]          K_LAST   = 3'(N_TERMS - 2);
    localparam logic [MAG_W-1:0]    RND_HALF = MAG_W'(1 << (RND_SHR - 1));
    localparam logic [INT_BITS_O-1:0] PI_HALF = INT_BITS_O'(PI_HALF_Q8);

    state_t                  state, state_nxt;
    logic                    sign_q;
    logic [MAG_W-1:0]        x2_q, p_q, acc_q;
    logic [2:0]              k_q;
    logic [IN_EXT_W-1:0]     x_ext, x_abs;
    logic                    x_oor;
    logic [MAG_W-1:0]        x_mag, mul_a, mul_b, acc_sum;
    logic [PROD_W-Q_IN_FRAC-1:0] mul_y;
    logic [INT_BITS_O-1:0]   out_mag, out_val, asinx_q;
    logic                    load_out, res_vld_q;
`ifdef ARCSIN_SAT_EN
    logic                    sat_q, range_err_q;
`endif

    // Magnitude is one bit wider than the input so that -32768 becomes +32768 rather than wrapping
    assign x_ext = {x_i[INT_BITS_I-1], x_i};
    assign x_abs = x_i[INT_BITS_I-1] ? (~x_ext + LSB_IN) : x_ext;
    assign x_oor = x_abs > ONE_IN;
    assign x_mag = x_oor ? MAG_W'(ONE_IN) : MAG_W'(x_abs);

    assign in_rdy_o = (state == IDLE);

    // Operand mux for the single shared multiplier: square, power step, coefficient product
    always_comb begin
        mul_a = p_q;
        mul_b = x2_q;
        case (state)
            SQR:     mul_b = p_q;
            ACC:     mul_b = {2'b00, COEF[k_q[1:0]]};
            default: mul_b = x2_q;
        endcase
    end

    fxp_mul_shr #(
        .W    (MAG_W),
        .SHIFT(Q_IN_FRAC)
    ) u_mul (
        .a(mul_a),
        .b(mul_b),
        .y(mul_y)
    );

    assign acc_sum = acc_q + MAG_W'(mul_y >> ACC_EXTRA_SHR);
    assign out_mag = INT_BITS_O'((acc_sum + RND_HALF) >> RND_SHR);

    // Result selection: sign applied last to the rounded magnitude keeps the function exactly odd
    always_comb begin
        out_val = sign_q ? (-out_mag) : out_mag;
`ifdef ARCSIN_SAT_EN
        if (sat_q) begin
            out_val = sign_q ? (-PI_HALF) : PI_HALF;
        end
`endif
    end

    // Next-state logic of the iteration sequencer
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (arg_vld_i) state_nxt = SQR;
            SQR: begin
                state_nxt = POW;
`ifdef ARCSIN_SAT_EN
                if (sat_q) state_nxt = OUT;
`endif
            end
            POW:     state_nxt = ACC;
            ACC:     state_nxt = (k_q < K_LAST) ? POW : OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The result is registered on the edge that enters OUT, so res_vld_o is high during OUT
    assign load_out = (state != OUT) && (state_nxt == OUT);

    // State register
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) state <= IDLE;
        else           state <= state_nxt;
    end

    // Series datapath: latch argument, square it, then alternate power and accumulate steps
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sign_q <= 1'b0;
            x2_q   <= '0;
            p_q    <= '0;
            acc_q  <= '0;
            k_q    <= '0;
`ifdef ARCSIN_SAT_EN
            sat_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (arg_vld_i) begin
                        sign_q <= x_i[INT_BITS_I-1];
                        p_q    <= x_mag;
                        acc_q  <= x_mag;
                        k_q    <= '0;
`ifdef ARCSIN_SAT_EN
                        sat_q  <= x_oor;
`endif
                    end
                end
                SQR: x2_q <= MAG_W'(mul_y);
                POW: p_q  <= MAG_W'(mul_y);
                ACC: begin
                    acc_q <= acc_sum;
                    k_q   <= k_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Output registers: value held between results, valid is a single-cycle pulse
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            asinx_q     <= '0;
            res_vld_q   <= 1'b0;
`ifdef ARCSIN_SAT_EN
            range_err_q <= 1'b0;
`endif
        end else begin
            res_vld_q <= load_out;
            if (load_out) asinx_q <= out_val;
`ifdef ARCSIN_SAT_EN
            range_err_q <= load_out && (state == SQR);
`endif
        end
    end

    assign asinx_o   = asinx_q;
    assign res_vld_o = res_vld_q;
`ifdef ARCSIN_SAT_EN
    assign range_err_o = range_err_q;
`endif

endmodule
